// File: rtl/sel_mux_pipe_pkg.sv
// Shared types and helpers for the registered N-way select pipeline.
package sel_mux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // All-ones ceiling; counters truncate it to their own width.
  localparam int unsigned MAX_CNT = 32'hFFFF_FFFF;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sel_mux_pipe_if.sv
// Ready/valid bus between the sources, the selector and its downstream consumer.
interface sel_mux_pipe_if #(
  parameter int WIDTH  = 2,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        data_out;
  logic                    sel_err;
  logic [CNT_W-1:0]        err_cnt;

  modport master (
    output in_valid, sel, data_in, out_ready,
    input  in_ready, out_valid, data_out, sel_err, err_cnt
  );

  modport slave (
    input  in_valid, sel, data_in, out_ready,
    output in_ready, out_valid, data_out, sel_err, err_cnt
  );

endinterface

// File: rtl/sel_mux_pipe_sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by clr.
module sat_counter
  import sel_mux_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_p1 <= '0;
    end else if (inc && (cnt_p1 != LIMIT)) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  assign cnt = cnt_p1;

endmodule

// File: rtl/sel_mux_pipe.sv
// Registered N-way selector with a one-entry ready/valid output stage; every
// select code, including out-of-range and unknown ones, yields a defined output.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter int               NUM_IN      = 3,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b1}},
  parameter bit               HOLD_ON_ERR = 1'b0,
  parameter int               CNT_W       = 8
) (
  input logic           clk,
  input logic           rst,
  sel_mux_pipe_if.slave bus
);

  if (SEL_W < clog2(NUM_IN)) begin : g_sel_w_check
    $error("sel_mux_pipe: SEL_W too narrow for NUM_IN");
  end

  state_t           state_p1, state_nxt;
  logic             vld_p1;
  logic             in_ready;
  logic             accept;
  logic             sel_bad;
  logic [WIDTH-1:0] chan;
  logic [WIDTH-1:0] dec_data;
  logic [WIDTH-1:0] data_p1;
  logic             err_p1;
  logic [WIDTH-1:0] last_good_p1;

  // ---- stage 0: combinational decode of the incoming beat ----
  always_comb begin
    chan     = '0;
    sel_bad  = 1'b1;
    dec_data = DEFAULT_VAL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        chan    = bus.data_in[k*WIDTH +: WIDTH];
        sel_bad = 1'b0;
      end
    end
`ifndef SYNTHESIS
    // An unknown select must never leak X into the datapath.
    if ($isunknown(bus.sel)) sel_bad = 1'b1;
`endif
    case (sel_bad)
      1'b0:    dec_data = chan;
      default: dec_data = HOLD_ON_ERR ? last_good_p1 : DEFAULT_VAL;
    endcase
  end

  assign accept = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= ST_EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (bus.out_ready && !bus.in_valid) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    vld_p1   = (state_p1 == ST_FULL);
    in_ready = !vld_p1 || bus.out_ready;
  end

  // ---- stage 1: output register, loaded only on an accepted beat ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1      <= '0;
      err_p1       <= 1'b0;
      last_good_p1 <= '0;
    end else if (accept) begin
      data_p1 <= dec_data;
      err_p1  <= sel_bad;
      if (!sel_bad) last_good_p1 <= chan;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .inc (accept & sel_bad),
    .clr (rst),
    .cnt (bus.err_cnt)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.data_out  = data_p1;
  assign bus.sel_err   = err_p1;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Randomized and directed bench for sel_mux_pipe; three configurations share one stimulus.
module tb_sel_mux_pipe;

  localparam int W  = 2;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam logic [5:0] D = {2'b10, 2'b01, 2'b00};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [N*W-1:0] data_in = '0;

  always #5 clk = ~clk;

  sel_mux_pipe_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .CNT_W(8)) b0 ();
  sel_mux_pipe_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .CNT_W(8)) b1 ();
  sel_mux_pipe_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .CNT_W(3)) b2 ();

  assign b0.in_valid = in_valid;  assign b0.out_ready = out_ready;
  assign b0.sel = sel;            assign b0.data_in = data_in;
  assign b1.in_valid = in_valid;  assign b1.out_ready = out_ready;
  assign b1.sel = sel;            assign b1.data_in = data_in;
  assign b2.in_valid = in_valid;  assign b2.out_ready = out_ready;
  assign b2.sel = sel;            assign b2.data_in = data_in;

  sel_mux_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .DEFAULT_VAL(2'b11), .HOLD_ON_ERR(1'b0), .CNT_W(8))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  sel_mux_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .DEFAULT_VAL(2'b11), .HOLD_ON_ERR(1'b1), .CNT_W(8))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  sel_mux_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .DEFAULT_VAL(2'b11), .HOLD_ON_ERR(1'b0), .CNT_W(3))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  // Reference: queue of beats the consumer should see, in order.
  typedef struct {
    logic [1:0] d_def;
    logic [1:0] d_hold;
    logic       err;
  } beat_t;

  beat_t      q[$];
  int         badcnt = 0;
  logic [1:0] lg = 2'b00;
  int         total = 0;
  int         bad = 0;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_clear();
    q.delete();
    badcnt = 0;
    lg = 2'b00;
  endtask

  // Drive one cycle of inputs, advance the reference, sample at the next negedge.
  task automatic drive_cycle(input logic v, input logic [1:0] s, input logic [5:0] d, input logic r);
    beat_t b;
    logic  room;
    logic  isbad;
    in_valid = v; sel = s; data_in = d; out_ready = r;
    room = (q.size() == 0) || r;
    if ((q.size() != 0) && r) void'(q.pop_front());
    if (v && room) begin
      isbad = $isunknown(s) ? 1'b1 : (s >= 2'd3);
      if (isbad) begin
        b.d_def = 2'b11; b.d_hold = lg; b.err = 1'b1;
        badcnt++;
      end else begin
        b.d_def = d[s*2 +: 2]; b.d_hold = b.d_def; b.err = 1'b0;
        lg = b.d_def;
      end
      q.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0; data_in = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset(2);
    total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", b0.out_valid); end
    total++; if (b0.data_out !== 2'b00) begin bad++; $display("FAIL reset data_out got=%b exp=00", b0.data_out); end
    total++; if (b0.err_cnt !== 8'd0 || b2.err_cnt !== 3'd0) begin bad++; $display("FAIL reset err_cnt got=%0d/%0d exp=0/0", b0.err_cnt, b2.err_cnt); end
    total++; if (b0.in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b exp=1", b0.in_ready); end
    total++; if (b0.sel_err !== 1'b0) begin bad++; $display("FAIL reset sel_err got=%b exp=0", b0.sel_err); end
  endtask

  task automatic test_basic();
    logic [1:0] exp;
    logic [1:0] s;
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      s = 2'(i);
      exp = 2'(i);
      drive_cycle(1'b1, s, D, 1'b1);
      total++;
      if (b0.out_valid !== 1'b1 || b0.data_out !== exp || b0.sel_err !== 1'b0)
        begin bad++; $display("FAIL basic sel%0d got v=%b d=%b e=%b exp v=1 d=%b e=0", i, b0.out_valid, b0.data_out, b0.sel_err, exp); end
    end
    drive_cycle(1'b0, 2'd0, D, 1'b1);
    total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL basic drain out_valid got=%b exp=0", b0.out_valid); end
  endtask

  task automatic test_bad_sel();
    do_reset(1);
    drive_cycle(1'b1, 2'd2, D, 1'b1);
    drive_cycle(1'b1, 2'd3, D, 1'b1);
    total++; if (b0.data_out !== 2'b11 || b0.sel_err !== 1'b1) begin bad++; $display("FAIL badsel default got d=%b e=%b exp d=11 e=1", b0.data_out, b0.sel_err); end
    total++; if (b0.err_cnt !== 8'd1) begin bad++; $display("FAIL badsel err_cnt got=%0d exp=1", b0.err_cnt); end
    total++; if (b1.data_out !== 2'b10 || b1.sel_err !== 1'b1) begin bad++; $display("FAIL badsel hold got d=%b e=%b exp d=10 e=1", b1.data_out, b1.sel_err); end
    drive_cycle(1'b1, 2'd0, D, 1'b1);
    total++; if (b0.sel_err !== 1'b0 || b0.data_out !== 2'b00) begin bad++; $display("FAIL badsel recover got d=%b e=%b exp d=00 e=0", b0.data_out, b0.sel_err); end
    drive_cycle(1'b0, 2'd0, D, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [1:0] s;
    do_reset(1);
    drive_cycle(1'b1, 2'd0, D, 1'b0);
    for (int i = 0; i < 4; i++) begin
      s = 2'((i % 2) + 1);
      drive_cycle(1'b1, s, D, 1'b0);
      total++;
      if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1 || b0.data_out !== 2'b00)
        begin bad++; $display("FAIL stall%0d got rdy=%b v=%b d=%b exp rdy=0 v=1 d=00", i, b0.in_ready, b0.out_valid, b0.data_out); end
    end
    drive_cycle(1'b1, 2'd1, D, 1'b1);
    total++; if (b0.out_valid !== 1'b1 || b0.data_out !== 2'b01) begin bad++; $display("FAIL release got v=%b d=%b exp v=1 d=01", b0.out_valid, b0.data_out); end
    drive_cycle(1'b0, 2'd0, D, 1'b1);
    total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL release drain out_valid got=%b exp=0", b0.out_valid); end
  endtask

  task automatic test_saturate();
    do_reset(1);
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 2'd3, D, 1'b1);
    total++; if (b2.err_cnt !== 3'd7) begin bad++; $display("FAIL sat cnt3 got=%0d exp=7", b2.err_cnt); end
    total++; if (b0.err_cnt !== 8'd10) begin bad++; $display("FAIL sat cnt8 got=%0d exp=10", b0.err_cnt); end
    do_reset(1);
    total++; if (b2.err_cnt !== 3'd0) begin bad++; $display("FAIL sat clear got=%0d exp=0", b2.err_cnt); end
  endtask

  task automatic test_x_sel();
    do_reset(1);
    drive_cycle(1'b1, 2'bxx, D, 1'b1);
    total++; if ($isunknown(b0.data_out)) begin bad++; $display("FAIL xsel data_out unknown got=%b", b0.data_out); end
    total++;
    if (q.size() == 0 || b0.data_out !== q[0].d_def || b0.sel_err !== q[0].err)
      begin bad++; $display("FAIL xsel got d=%b e=%b exp d=%b e=%b", b0.data_out, b0.sel_err, (q.size() != 0) ? q[0].d_def : 2'b00, (q.size() != 0) ? q[0].err : 1'b0); end
    drive_cycle(1'b1, 2'd1, D, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) begin bad++; $display("FAIL rst_full got v=%b rdy=%b exp v=0 rdy=1", b0.out_valid, b0.in_ready); end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_random(input int n);
    logic v, r;
    logic [1:0] s;
    logic [5:0] d;
    do_reset(1);
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      s = 2'($urandom_range(0, 3));
      d = 6'($urandom);
      drive_cycle(v, s, d, r);
      total++;
      if (b0.out_valid !== (q.size() != 0) || b1.out_valid !== (q.size() != 0))
        begin bad++; $display("FAIL rand%0d out_valid got=%b exp=%b", i, b0.out_valid, (q.size() != 0)); end
      if (q.size() != 0) begin
        total++;
        if (b0.data_out !== q[0].d_def || b1.data_out !== q[0].d_hold || b2.data_out !== q[0].d_def ||
            b0.sel_err !== q[0].err || b1.sel_err !== q[0].err)
          begin bad++; $display("FAIL rand%0d data got d0=%b d1=%b e=%b exp d0=%b d1=%b e=%b", i, b0.data_out, b1.data_out, b0.sel_err, q[0].d_def, q[0].d_hold, q[0].err); end
      end
      total++;
      if (b0.err_cnt !== 8'(sat(badcnt, 255)) || b2.err_cnt !== 3'(sat(badcnt, 7)))
        begin bad++; $display("FAIL rand%0d err_cnt got=%0d/%0d exp=%0d/%0d", i, b0.err_cnt, b2.err_cnt, sat(badcnt, 255), sat(badcnt, 7)); end
      total++;
      if (b0.in_ready !== ((q.size() == 0) || r))
        begin bad++; $display("FAIL rand%0d in_ready got=%b exp=%b", i, b0.in_ready, ((q.size() == 0) || r)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_sel();
    test_backpressure();
    test_saturate();
    test_x_sel();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
